// File: rtl/mcontr_arbiter.sv
// SDRAM access arbiter: eight round-robin channels plus a top-priority refresh requester.
// Grants open with a one-cycle start pulse and close on done or watchdog expiry; state updates on negedge clk0.
module mcontr_arbiter #(
    parameter int REFRESH_PERIOD = 780,
    parameter int BUSY_TIMEOUT   = 1023
) (
    input  logic       clk0,
    input  logic       nrst,
    input  logic [7:0] rq,
    input  logic [8:0] enrq_chn,
    input  logic [8:0] init_chn,
    input  logic       done,
    output logic [8:0] gnt,
    output logic [3:0] gnt_num,
    output logic       start,
    output logic       busy,
    output logic       timeout_err,
    output logic [1:0] ref_pending
);
    localparam int TW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam int WW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(REFRESH_PERIOD - 1);
    localparam logic [WW-1:0] WD_LAST    = WW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t          state_r;
    logic [8:0]      gnt_r;
    logic [3:0]      gnt_num_r;
    logic            start_r;
    logic            busy_r;
    logic            timeout_err_r;
    logic [1:0]      ref_pending_r;
    logic [TW-1:0]   timer_r;
    logic [WW-1:0]   wd_cnt_r;
    logic [2:0]      rr_ptr_r;

    logic [7:0]      elig_s;
    logic            ref_elig_s;
    logic            any_elig_s;
    logic [2:0]      win_s;
    logic            tick_s;
    logic            ref_dec_s;
    logic [1:0]      ref_next_s;

    assign elig_s     = rq & enrq_chn[7:0] & ~init_chn[7:0];
    assign ref_elig_s = (ref_pending_r != 2'd0) & enrq_chn[8] & ~init_chn[8];
    assign any_elig_s = |elig_s;
    assign tick_s     = (timer_r == TW'(0));
    assign ref_dec_s  = (state_r == ST_IDLE) && ref_elig_s;

    // Round-robin winner: scanning from ptr+8 down to ptr+1 lets the nearest eligible channel after ptr win.
    always_comb begin
        win_s = 3'd0;
        for (int k = 8; k >= 1; k--) begin
            win_s = elig_s[rr_ptr_r + 3'(k)] ? (rr_ptr_r + 3'(k)) : win_s;
        end
    end

    // Outstanding-refresh count; a coincident tick and grant cancel so the count saturates cleanly at 2.
    always_comb begin
        ref_next_s = ref_pending_r;
        if (init_chn[8]) begin
            ref_next_s = 2'd0;
        end else if (tick_s && !ref_dec_s) begin
            ref_next_s = (ref_pending_r == 2'd2) ? 2'd2 : ref_pending_r + 2'd1;
        end else if (!tick_s && ref_dec_s) begin
            ref_next_s = ref_pending_r - 2'd1;
        end else begin
            ref_next_s = ref_pending_r;
        end
    end

    // Refresh interval timer and pending counter.
    always_ff @(negedge clk0 or negedge nrst) begin
        if (!nrst) begin
            timer_r       <= TIMER_LOAD;
            ref_pending_r <= 2'd0;
        end else begin
            ref_pending_r <= ref_next_s;
            if (init_chn[8] || tick_s) begin
                timer_r <= TIMER_LOAD;
            end else begin
                timer_r <= timer_r - TW'(1);
            end
        end
    end

    // Grant FSM with registered outputs; only done or the watchdog can end a grant.
    always_ff @(negedge clk0 or negedge nrst) begin
        if (!nrst) begin
            state_r       <= ST_IDLE;
            gnt_r         <= 9'h000;
            gnt_num_r     <= 4'd0;
            start_r       <= 1'b0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            wd_cnt_r      <= '0;
            rr_ptr_r      <= 3'd7;
        end else begin
            start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ref_elig_s) begin
                        state_r   <= ST_START;
                        gnt_r     <= 9'h100;
                        gnt_num_r <= 4'd8;
                        start_r   <= 1'b1;
                        busy_r    <= 1'b1;
                    end else if (any_elig_s) begin
                        state_r   <= ST_START;
                        gnt_r     <= 9'h001 << win_s;
                        gnt_num_r <= {1'b0, win_s};
                        rr_ptr_r  <= win_s;
                        start_r   <= 1'b1;
                        busy_r    <= 1'b1;
                    end else begin
                        gnt_r <= 9'h000;
                    end
                end
                ST_START: begin
                    wd_cnt_r <= '0;
                    if (done) begin
                        state_r <= ST_GAP;
                        gnt_r   <= 9'h000;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (done) begin
                        state_r <= ST_GAP;
                        gnt_r   <= 9'h000;
                        busy_r  <= 1'b0;
                    end else if (wd_cnt_r == WD_LAST) begin
                        state_r       <= ST_GAP;
                        gnt_r         <= 9'h000;
                        busy_r        <= 1'b0;
                        timeout_err_r <= 1'b1;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + WW'(1);
                    end
                end
                ST_GAP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= 9'h000;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt         = gnt_r;
    assign gnt_num     = gnt_num_r;
    assign start       = start_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_err_r;
    assign ref_pending = ref_pending_r;

endmodule

// File: tb/tb_mcontr_arbiter.sv
// Scoreboard bench for mcontr_arbiter: expected grant indices are queued with the stimulus
// and compared whenever the arbiter raises start.
module tb_mcontr_arbiter;
    logic       clk0;
    logic       nrst;
    logic [7:0] rq;
    logic [8:0] enrq_chn;
    logic [8:0] init_chn;
    logic       done;
    logic [8:0] gnt;
    logic [3:0] gnt_num;
    logic       start;
    logic       busy;
    logic       timeout_err;
    logic [1:0] ref_pending;

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];

    mcontr_arbiter #(.REFRESH_PERIOD(16), .BUSY_TIMEOUT(8)) dut (
        .clk0        (clk0),
        .nrst        (nrst),
        .rq          (rq),
        .enrq_chn    (enrq_chn),
        .init_chn    (init_chn),
        .done        (done),
        .gnt         (gnt),
        .gnt_num     (gnt_num),
        .start       (start),
        .busy        (busy),
        .timeout_err (timeout_err),
        .ref_pending (ref_pending)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    // DUT updates on negedge; inputs are driven and outputs sampled on posedge.
    task automatic do_reset();
        nrst = 1'b0; rq = 8'h00; enrq_chn = 9'h1FF; init_chn = 9'h000; done = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk0);
        nrst = 1'b1;
    endtask

    task automatic wait_start(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(posedge clk0);
            found = start;
        end
    endtask

    task automatic test_reset();
        bit found; int e; logic [8:0] eg;
        do_reset();
        rq = 8'h01;
        wait_start(10, found);
        vectors++;
        if (!found) begin miscompares++; $display("FAIL reset_pre_grant: start=0, required start=1"); end
        @(posedge clk0);
        nrst = 1'b0;
        #1;
        vectors++;
        if (gnt !== 9'h000 || gnt_num !== 4'd0 || start !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: gnt=%h gnt_num=%0d start=%b busy=%b, required 000 0 0 0", gnt, gnt_num, start, busy);
        end
        vectors++;
        if (timeout_err !== 1'b0 || ref_pending !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_flags: timeout_err=%b ref_pending=%0d, required 0 0", timeout_err, ref_pending);
        end
        @(posedge clk0);
        nrst = 1'b1;
        exp_q.push_back(0);
        wait_start(10, found);
        vectors++;
        if (!found) begin
            miscompares++; $display("FAIL reset_regrant: no start seen, required start");
        end else begin
            e = exp_q.pop_front(); eg = 9'h001 << e;
            if (gnt !== eg || gnt_num !== 4'(e)) begin
                miscompares++; $display("FAIL reset_regrant: gnt=%h gnt_num=%0d, required %h %0d", gnt, gnt_num, eg, e);
            end
        end
        done = 1'b1; rq = 8'h00;
        @(posedge clk0);
        done = 1'b0;
    endtask

    task automatic test_basic();
        bit found; int e; logic [8:0] eg;
        do_reset();
        rq = 8'h05;
        exp_q.push_back(0); exp_q.push_back(2);
        for (int g = 0; g < 2; g++) begin
            wait_start(10, found);
            vectors++;
            if (!found) begin
                miscompares++; $display("FAIL basic_grant%0d: no start seen, required start", g);
            end else begin
                e = exp_q.pop_front(); eg = 9'h001 << e;
                if (gnt !== eg || gnt_num !== 4'(e) || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL basic_grant%0d: gnt=%h gnt_num=%0d busy=%b, required %h %0d 1", g, gnt, gnt_num, busy, eg, e);
                end
            end
            if (g == 1) rq = 8'h00;
            done = 1'b1;
            @(posedge clk0);
            done = 1'b0;
            vectors++;
            if (gnt !== 9'h000 || busy !== 1'b0) begin
                miscompares++; $display("FAIL basic_gap%0d: gnt=%h busy=%b, required 000 0", g, gnt, busy);
            end
        end
    endtask

    task automatic test_round_robin();
        bit found; int e; logic [8:0] eg;
        do_reset();
        init_chn = 9'h100;
        rq = 8'hFF;
        for (int i = 0; i < 9; i++) exp_q.push_back(i % 8);
        for (int g = 0; g < 9; g++) begin
            wait_start(10, found);
            vectors++;
            if (!found) begin
                miscompares++; $display("FAIL rr_grant%0d: no start seen, required start", g);
            end else begin
                e = exp_q.pop_front(); eg = 9'h001 << e;
                if (gnt !== eg || gnt_num !== 4'(e)) begin
                    miscompares++; $display("FAIL rr_grant%0d: gnt=%h gnt_num=%0d, required %h %0d", g, gnt, gnt_num, eg, e);
                end
            end
            @(posedge clk0);
            vectors++;
            if (start !== 1'b0 || busy !== 1'b1 || gnt !== eg) begin
                miscompares++; $display("FAIL rr_busy%0d: start=%b busy=%b gnt=%h, required 0 1 %h", g, start, busy, gnt, eg);
            end
            repeat (2) @(posedge clk0);
            done = 1'b1;
            if (g == 8) rq = 8'h00;
            @(posedge clk0);
            done = 1'b0;
            vectors++;
            if (gnt !== 9'h000 || busy !== 1'b0) begin
                miscompares++; $display("FAIL rr_gap%0d: gnt=%h busy=%b, required 000 0", g, gnt, busy);
            end
        end
    endtask

    task automatic test_refresh();
        bit found; int e; logic [8:0] eg;
        do_reset();
        repeat (15) @(posedge clk0);
        vectors++;
        if (ref_pending !== 2'd0) begin
            miscompares++; $display("FAIL ref_before_tick: ref_pending=%0d, required 0", ref_pending);
        end
        @(posedge clk0);
        vectors++;
        if (ref_pending !== 2'd1) begin
            miscompares++; $display("FAIL ref_tick: ref_pending=%0d, required 1", ref_pending);
        end
        rq = 8'h09;
        exp_q.push_back(8); exp_q.push_back(0); exp_q.push_back(3);
        for (int g = 0; g < 3; g++) begin
            wait_start(10, found);
            vectors++;
            if (!found) begin
                miscompares++; $display("FAIL ref_grant%0d: no start seen, required start", g);
            end else begin
                e = exp_q.pop_front(); eg = 9'h001 << e;
                if (gnt !== eg || gnt_num !== 4'(e) || (e == 8 && ref_pending !== 2'd0)) begin
                    miscompares++;
                    $display("FAIL ref_grant%0d: gnt=%h gnt_num=%0d ref_pending=%0d, required %h %0d", g, gnt, gnt_num, ref_pending, eg, e);
                end
            end
            done = 1'b1;
            if (g == 2) begin rq = 8'h00; enrq_chn = 9'h0FF; end
            @(posedge clk0);
            done = 1'b0;
        end
        repeat (50) @(posedge clk0);
        vectors++;
        if (ref_pending !== 2'd2 || timeout_err !== 1'b0) begin
            miscompares++; $display("FAIL ref_saturate: ref_pending=%0d timeout_err=%b, required 2 0", ref_pending, timeout_err);
        end
        init_chn = 9'h100;
        @(posedge clk0);
        init_chn = 9'h000;
        vectors++;
        if (ref_pending !== 2'd0) begin
            miscompares++; $display("FAIL ref_init_clear: ref_pending=%0d, required 0", ref_pending);
        end
    endtask

    task automatic test_timeout();
        bit found; int e; logic [8:0] eg;
        do_reset();
        init_chn = 9'h100;
        rq = 8'h02;
        exp_q.push_back(1);
        wait_start(10, found);
        vectors++;
        if (!found) begin
            miscompares++; $display("FAIL to_grant: no start seen, required start");
        end else begin
            e = exp_q.pop_front(); eg = 9'h001 << e;
            if (gnt !== eg || gnt_num !== 4'(e)) begin
                miscompares++; $display("FAIL to_grant: gnt=%h gnt_num=%0d, required %h %0d", gnt, gnt_num, eg, e);
            end
        end
        rq = 8'h00; enrq_chn = 9'h1FD; init_chn = 9'h102;
        repeat (8) @(posedge clk0);
        vectors++;
        if (gnt !== 9'h002 || busy !== 1'b1 || timeout_err !== 1'b0) begin
            miscompares++; $display("FAIL to_last_busy: gnt=%h busy=%b timeout_err=%b, required 002 1 0", gnt, busy, timeout_err);
        end
        @(posedge clk0);
        vectors++;
        if (timeout_err !== 1'b1 || gnt !== 9'h000 || busy !== 1'b0) begin
            miscompares++; $display("FAIL to_expire: timeout_err=%b gnt=%h busy=%b, required 1 000 0", timeout_err, gnt, busy);
        end
        enrq_chn = 9'h1FF; init_chn = 9'h100; rq = 8'h04;
        exp_q.push_back(2);
        wait_start(10, found);
        vectors++;
        if (!found) begin
            miscompares++; $display("FAIL to_next_grant: no start seen, required start");
        end else begin
            e = exp_q.pop_front(); eg = 9'h001 << e;
            if (gnt !== eg || gnt_num !== 4'(e)) begin
                miscompares++; $display("FAIL to_next_grant: gnt=%h gnt_num=%0d, required %h %0d", gnt, gnt_num, eg, e);
            end
        end
        done = 1'b1; rq = 8'h00;
        @(posedge clk0);
        done = 1'b0;
        vectors++;
        if (timeout_err !== 1'b1) begin
            miscompares++; $display("FAIL to_sticky: timeout_err=%b, required 1", timeout_err);
        end
    endtask

    task automatic test_init();
        bit found; bit seen; int e; logic [8:0] eg;
        do_reset();
        init_chn = 9'h104;
        rq = 8'h06;
        for (int i = 0; i < 3; i++) exp_q.push_back(1);
        for (int g = 0; g < 3; g++) begin
            wait_start(10, found);
            vectors++;
            if (!found) begin
                miscompares++; $display("FAIL init_grant%0d: no start seen, required start", g);
            end else begin
                e = exp_q.pop_front(); eg = 9'h001 << e;
                if (gnt !== eg || gnt_num !== 4'(e)) begin
                    miscompares++; $display("FAIL init_grant%0d: gnt=%h gnt_num=%0d, required %h %0d", g, gnt, gnt_num, eg, e);
                end
            end
            done = 1'b1;
            @(posedge clk0);
            done = 1'b0;
        end
        rq = 8'h04;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk0);
            seen = seen | start;
        end
        vectors++;
        if (seen !== 1'b0 || ref_pending !== 2'd0) begin
            miscompares++; $display("FAIL init_block: start_seen=%b ref_pending=%0d, required 0 0", seen, ref_pending);
        end
        rq = 8'h00;
    endtask

    initial begin
        nrst = 1'b0; rq = 8'h00; enrq_chn = 9'h1FF; init_chn = 9'h000; done = 1'b0;
        test_reset();
        test_basic();
        test_round_robin();
        test_refresh();
        test_timeout();
        test_init();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
